// File: rtl/adc_spi_sample_reader_pkg.sv
// Shared types and constants for the AD7980-class ADC SPI sample reader.
package adc_spi_sample_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    localparam logic FMT_BINARY = 1'b0;
    localparam logic FMT_TWOS   = 1'b1;

endpackage

// File: rtl/adc_spi_sample_reader_if.sv
// 3-wire ADC serial bus: convert strobe and serial clock out, serial data back.
interface adc_spi_sample_reader_if;

    logic ADC_CNV;
    logic ADC_SCLK;
    logic ADC_SDO;

    modport master (
        output ADC_CNV,
        output ADC_SCLK,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CNV,
        input  ADC_SCLK,
        output ADC_SDO
    );

endinterface

// File: rtl/adc_spi_sck_gen.sv
// SCK divider: SCK_HALF cycles low then SCK_HALF cycles high per period, starting
// low whenever enabled; strobes on the last high cycle of every period.
module adc_spi_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic dataclk,
    input  logic reset,
    input  logic en,
    output logic sck_level,
    output logic sample_strobe
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [HW-1:0] half_cnt;
    logic          last_half;

    assign last_half     = (half_cnt == HW'(SCK_HALF - 1));
    assign sample_strobe = en & sck_level & last_half;

    // Half-period counter and SCK level, parked low at phase zero while disabled
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            half_cnt  <= '0;
            sck_level <= 1'b0;
        end else if (!en) begin
            half_cnt  <= '0;
            sck_level <= 1'b0;
        end else if (last_half) begin
            half_cnt  <= '0;
            sck_level <= ~sck_level;
        end else begin
            half_cnt  <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/adc_spi_sample_reader.sv
// SPI read master for a 16-bit SAR ADC: pulses CNV, clocks a conversion in MSB-first,
// presents it as offset binary with a one-cycle valid, and drives a threshold compare.
module adc_spi_sample_reader
    import adc_spi_sample_reader_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CONV_CYCLES = 20,
    parameter int SCK_HALF    = 2
) (
    input  logic                     dataclk,
    input  logic                     reset,
    input  logic                     ADC_en,
    input  logic                     start,
    input  logic                     data_format,
    adc_spi_sample_reader_if.master  spi,
    output logic [DATA_W-1:0]        sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clear_overrun,
    input  logic [DATA_W-1:0]        thrsh,
    input  logic                     thrsh_pol,
    output logic                     thrsh_out
);

    localparam int CNT_MAX = (CONV_CYCLES > SCK_HALF) ? CONV_CYCLES : SCK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(DATA_W);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               sdo_q;
    logic               cnv_q;
    logic               sck_level;
    logic               sample_strobe;
    logic               last_bit;

    assign last_bit     = (bit_idx == IDX_W'(DATA_W - 1));
    assign spi.ADC_CNV  = cnv_q;
    assign spi.ADC_SCLK = sck_level;

    adc_spi_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .dataclk       (dataclk),
        .reset         (reset),
        .en            (state == SHIFT),
        .sck_level     (sck_level),
        .sample_strobe (sample_strobe)
    );

    // Next-state decode for the conversion/readout sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && ADC_en) state_next = CONV;
            CONV:    if (cnt == CNT_W'(CONV_CYCLES - 1)) state_next = SETUP;
            SETUP:   state_next = SHIFT;
            SHIFT:   if (sample_strobe && last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus CNV/busy, registered from the state being entered
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnv_q <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnv_q <= (state_next == CONV);
            busy  <= (state_next != IDLE);
        end
    end

    // Conversion-time counter, bit index, input flop and receive shift register
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            sdo_q   <= 1'b0;
        end else begin
            sdo_q <= spi.ADC_SDO;
            if (state == CONV && state_next == CONV) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (state != SHIFT) begin
                bit_idx <= '0;
            end else if (sample_strobe && !last_bit) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (sample_strobe) begin
                shreg <= {shreg[DATA_W-2:0], sdo_q};
            end
        end
    end

    // Result publication, sticky overrun flag and threshold comparator
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            thrsh_out    <= 1'b0;
        end else begin
            sample_valid <= (state == DONE);
            if (state == DONE) begin
                sample_out <= (data_format == FMT_TWOS) ?
                              {~shreg[DATA_W-1], shreg[DATA_W-2:0]} : shreg;
            end
            if (start && busy) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
            if (!ADC_en) begin
                thrsh_out <= 1'b0;
            end else begin
                thrsh_out <= thrsh_pol ? (sample_out >= thrsh) : (sample_out <= thrsh);
            end
        end
    end

endmodule
